// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO.
// One operation takes 33 edges from the Start sample to updated HI/LO:
// 32 shift-add / restoring-divide iterations followed by a sign-fix cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoSel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         r_state;
  logic [5:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // mul: running product; div: {remainder, quotient}
  logic [2*WIDTH-1:0] r_opa;     // mul: multiplicand shifted left; div: dividend bits, MSB at [WIDTH-1]
  logic [WIDTH-1:0]   r_opb;     // mul: multiplier shifted right; div: divisor (held)
  logic [1:0]         r_op;      // [1] = divide, [0] = signed
  logic               r_sign_q;  // product / quotient must be negated
  logic               r_sign_r;  // remainder must be negated
  logic [WIDTH-1:0]   r_orig_a;  // unmodified dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_mul_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_div0;

  // Operand magnitudes (signed ops only) and one iteration of each datapath
  always_comb begin
    w_a_neg    = Op[0] & A[WIDTH-1];
    w_b_neg    = Op[0] & B[WIDTH-1];
    w_a_mag    = w_a_neg ? (~A + 1'b1) : A;
    w_b_mag    = w_b_neg ? (~B + 1'b1) : B;
    w_mul_sum  = r_acc + (r_opb[0] ? r_opa : '0);
    // Restoring divide: the shifted partial remainder can need WIDTH+1 bits
    w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_opa[WIDTH-1]};
    w_diff     = w_trial - {1'b0, r_opb};
    w_qbit     = ~w_diff[WIDTH];
    w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_prod_fix = r_sign_q ? (~r_acc + 1'b1) : r_acc;
    w_quo_fix  = r_sign_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_rem_fix  = r_sign_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
    w_div0     = (r_opb == '0);
  end

  // Control FSM and iterative datapath
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_orig_a <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op     <= Op;
            r_opa    <= {{WIDTH{1'b0}}, w_a_mag};
            r_opb    <= w_b_mag;
            r_orig_a <= A;
            r_sign_q <= w_a_neg ^ w_b_neg;
            r_sign_r <= w_a_neg;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_op[1]) begin
            r_acc <= {w_rem_next, r_acc[WIDTH-2:0], w_qbit};
          end else begin
            r_acc <= w_mul_sum;
            r_opb <= r_opb >> 1;
          end
          r_opa <= r_opa << 1;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // HI/LO write-back with sign correction, plus the Done pulse
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        if (!r_op[1]) begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end else if (w_div0) begin
          r_hi <= r_orig_a;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end
    end
  end

  assign Busy   = (r_state != S_IDLE);
  assign Done   = r_done;
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign result = HiLoSel ? r_hi : r_lo;

endmodule
